// File: rtl/rggen_pipelined_reducer.sv
// rtl/rggen_pipelined_reducer.sv - pipelined N-to-1 bitwise OR/AND/XOR reducer with valid/ready handshake
//
// Folds N words of WIDTH bits into one word through a radix-4 reduction tree.
// A register stage follows every REG_INTERVAL tree levels and always the last
// level, so there are D = ceil(L/REG_INTERVAL) stages, or D = 1 when N = 1.
//
// Parameters:
//   WIDTH        - bits per input word and of the result
//   N            - number of input words
//   OP           - 0 = OR, 1 = AND, 2 = XOR, anything else = OR
//   REG_INTERVAL - tree levels between pipeline registers
//
// Ports:
//   i_clk, i_rst_n - clock, asynchronous active-low reset
//   i_clear        - synchronous flush of every in-flight word
//   i_valid/o_ready/i_data   - input word set handshake
//   o_valid/i_ready/o_result - reduced word handshake
//
// Build option:
//   RGGEN_PIPELINED_REDUCER_DATA_RESET_EN - when defined, stage data registers
//   reset to zero; otherwise only the valid bits are reset.

module rggen_pipelined_reducer #(
    parameter int WIDTH        = 1,
    parameter int N            = 2,
    parameter int OP           = 0,
    parameter int REG_INTERVAL = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_clear,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [WIDTH*N-1:0]   i_data,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [WIDTH-1:0]     o_result
);

    // Word count entering tree level j.
    function automatic int level_count(input int j);
        int c;
        c = N;
        for (int i = 0; i < j; i++) c = (c + 3) / 4;
        return c;
    endfunction

    function automatic int num_levels(input int n);
        int c;
        int l;
        c = n;
        l = 0;
        while (c > 1) begin
            c = (c + 3) / 4;
            l++;
        end
        return l;
    endfunction

    function automatic logic [WIDTH-1:0] fold(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
        case (OP)
            1:       fold = a & b;
            2:       fold = a ^ b;
            default: fold = a | b;
        endcase
    endfunction

    localparam int L = num_levels(N);
    localparam int D = (L == 0) ? 1 : (L + REG_INTERVAL - 1) / REG_INTERVAL;

    logic [D-1:0] v;
    logic [D-1:0] v_up;
    logic [D-1:0] rdy;

    // Ready ripples back from the output: an empty stage always accepts, so
    // bubbles collapse without costing a cycle.
    always_comb begin
        logic r;
        r   = i_ready;
        rdy = '0;
        for (int k = D - 1; k >= 0; k--) begin
            r      = !v[k] | r;
            rdy[k] = r;
        end
    end

    always_comb begin
        v_up    = '0;
        v_up[0] = i_valid;
        for (int k = 1; k < D; k++) v_up[k] = v[k-1];
    end

    // Clear wins over a simultaneous input transfer; that word is dropped.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            v <= '0;
        end else if (i_clear) begin
            v <= '0;
        end else begin
            v <= (v & ~rdy) | (v_up & rdy);
        end
    end

    assign o_ready = rdy[0];
    assign o_valid = v[D-1];

    for (genvar j = 0; j < L; j++) begin : g_lvl
        localparam int NI     = level_count(j);
        localparam int NO     = level_count(j + 1);
        localparam bit IS_REG = (((j + 1) % REG_INTERVAL) == 0) || (j == L - 1);
        localparam int S      = j / REG_INTERVAL;

        logic [WIDTH*NI-1:0] din;
        logic [WIDTH*NO-1:0] sum;
        logic [WIDTH*NO-1:0] dout;

        if (j == 0) begin : g_src
            assign din = i_data;
        end else begin : g_src
            assign din = g_lvl[j-1].dout;
        end

        // Groups of four in order; the last group takes the remainder and a
        // single-member group is a pass-through.
        for (genvar g = 0; g < NO; g++) begin : g_grp
            localparam int M = ((NI - 4 * g) > 4) ? 4 : (NI - 4 * g);
            logic [WIDTH-1:0] acc;
            always_comb begin
                acc = din[WIDTH*4*g +: WIDTH];
                for (int m = 1; m < M; m++) begin
                    acc = fold(acc, din[WIDTH*(4*g+m) +: WIDTH]);
                end
            end
            assign sum[WIDTH*g +: WIDTH] = acc;
        end

        if (IS_REG) begin : g_reg
            logic [WIDTH*NO-1:0] q;
`ifdef RGGEN_PIPELINED_REDUCER_DATA_RESET_EN
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    q <= '0;
                end else if (rdy[S]) begin
                    q <= sum;
                end
            end
`else
            always_ff @(posedge i_clk) begin
                if (rdy[S]) begin
                    q <= sum;
                end
            end
`endif
            assign dout = q;
        end else begin : g_comb
            assign dout = sum;
        end
    end

    if (L == 0) begin : g_pass
        logic [WIDTH-1:0] q;
`ifdef RGGEN_PIPELINED_REDUCER_DATA_RESET_EN
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                q <= '0;
            end else if (rdy[0]) begin
                q <= i_data;
            end
        end
`else
        always_ff @(posedge i_clk) begin
            if (rdy[0]) begin
                q <= i_data;
            end
        end
`endif
        assign o_result = q;
    end else begin : g_out
        assign o_result = g_lvl[L-1].dout;
    end

endmodule

// File: tb/tb_rggen_pipelined_reducer.sv
// tb/tb_rggen_pipelined_reducer.sv - directed self-checking bench for rggen_pipelined_reducer

module tb_rggen_pipelined_reducer;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // OR, WIDTH=8, N=16, RI=1 (D=2)
    logic         or_valid, or_ordy, or_ovalid, or_iready;
    logic [127:0] or_data;
    logic [7:0]   or_res;
    // AND, WIDTH=4, N=5 (D=2)
    logic         and_valid, and_ordy, and_ovalid, and_iready;
    logic [19:0]  and_data;
    logic [3:0]   and_res;
    // XOR, WIDTH=4, N=5 (D=2)
    logic         xor_valid, xor_ordy, xor_ovalid, xor_iready;
    logic [19:0]  xor_data;
    logic [3:0]   xor_res;
    // OR, WIDTH=8, N=64, RI=1 (D=3)
    logic         bp_valid, bp_ordy, bp_ovalid, bp_iready, bp_clear;
    logic [511:0] bp_data;
    logic [7:0]   bp_res;
    // N=1, WIDTH=16 (D=1)
    logic         one_valid, one_ordy, one_ovalid, one_iready;
    logic [15:0]  one_data;
    logic [15:0]  one_res;

    rggen_pipelined_reducer #(.WIDTH(8), .N(16), .OP(0), .REG_INTERVAL(1)) u_or (
        .i_clk(clk), .i_rst_n(rst_n), .i_clear(1'b0), .i_valid(or_valid), .o_ready(or_ordy),
        .i_data(or_data), .o_valid(or_ovalid), .i_ready(or_iready), .o_result(or_res));
    rggen_pipelined_reducer #(.WIDTH(4), .N(5), .OP(1), .REG_INTERVAL(1)) u_and (
        .i_clk(clk), .i_rst_n(rst_n), .i_clear(1'b0), .i_valid(and_valid), .o_ready(and_ordy),
        .i_data(and_data), .o_valid(and_ovalid), .i_ready(and_iready), .o_result(and_res));
    rggen_pipelined_reducer #(.WIDTH(4), .N(5), .OP(2), .REG_INTERVAL(1)) u_xor (
        .i_clk(clk), .i_rst_n(rst_n), .i_clear(1'b0), .i_valid(xor_valid), .o_ready(xor_ordy),
        .i_data(xor_data), .o_valid(xor_ovalid), .i_ready(xor_iready), .o_result(xor_res));
    rggen_pipelined_reducer #(.WIDTH(8), .N(64), .OP(0), .REG_INTERVAL(1)) u_bp (
        .i_clk(clk), .i_rst_n(rst_n), .i_clear(bp_clear), .i_valid(bp_valid), .o_ready(bp_ordy),
        .i_data(bp_data), .o_valid(bp_ovalid), .i_ready(bp_iready), .o_result(bp_res));
    rggen_pipelined_reducer #(.WIDTH(16), .N(1), .OP(0), .REG_INTERVAL(1)) u_one (
        .i_clk(clk), .i_rst_n(rst_n), .i_clear(1'b0), .i_valid(one_valid), .o_ready(one_ordy),
        .i_data(one_data), .o_valid(one_ovalid), .i_ready(one_iready), .o_result(one_res));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Word n: value (n+1)*0x11 placed in one slot of the 64, all others zero.
    task automatic bp_put(input int n);
        bp_data = '0;
        bp_data[8*((n*13+5)%64) +: 8] = 8'((n + 1) * 17);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        or_valid = 0;  or_data = '0;  or_iready = 1;
        and_valid = 0; and_data = '0; and_iready = 1;
        xor_valid = 0; xor_data = '0; xor_iready = 1;
        bp_valid = 0;  bp_data = '0;  bp_iready = 1; bp_clear = 0;
        one_valid = 0; one_data = '0; one_iready = 1;

        #12;
        chk("rst_or_ovalid", 32'(or_ovalid), 32'h0);
        chk("rst_or_ordy", 32'(or_ordy), 32'h1);
        chk("rst_bp_ovalid", 32'(bp_ovalid), 32'h0);
        chk("rst_bp_ordy", 32'(bp_ordy), 32'h1);
        chk("rst_one_ovalid", 32'(one_ovalid), 32'h0);
`ifdef RGGEN_PIPELINED_REDUCER_DATA_RESET_EN
        chk("rst_or_res", 32'(or_res), 32'h0);
`endif
        #1 rst_n = 1'b1;
        tick;

        // Two back-to-back vectors into each small instance.
        or_data  = 128'h0000_0000_0000_0000_8040_2010_0804_0201;
        and_data = 20'h7FFFF;
        xor_data = 20'h20031;
        one_data = 16'hBEEF;
        or_valid = 1; and_valid = 1; xor_valid = 1; one_valid = 1;
        tick;
        chk("one_lat_valid", 32'(one_ovalid), 32'h1);
        chk("one_lat_res", 32'(one_res), 32'hBEEF);
        chk("or_lat_notyet", 32'(or_ovalid), 32'h0);
        or_data  = 128'h8000_0000_0000_0000_0000_0000_0000_0000;
        and_data = 20'hFFFFF;
        xor_data = 20'h80421;
        one_data = 16'h1234;
        tick;
        or_valid = 0; and_valid = 0; xor_valid = 0; one_valid = 0;
        chk("or_v1_valid", 32'(or_ovalid), 32'h1);
        chk("or_v1_res", 32'(or_res), 32'hFF);
        chk("and_v1_res", 32'(and_res), 32'h7);
        chk("xor_v1_valid", 32'(xor_ovalid), 32'h1);
        chk("xor_v1_res", 32'(xor_res), 32'h0);
        chk("one_v2_res", 32'(one_res), 32'h1234);
        tick;
        chk("or_v2_res", 32'(or_res), 32'h80);
        chk("and_v2_res", 32'(and_res), 32'hF);
        chk("xor_v2_res", 32'(xor_res), 32'hF);
        chk("one_drained", 32'(one_ovalid), 32'h0);
        tick;
        chk("or_drained", 32'(or_ovalid), 32'h0);
        chk("and_drained", 32'(and_ovalid), 32'h0);

        // Backpressure: three words fill D=3, the fourth is refused.
        bp_iready = 0;
        for (int n = 0; n < 3; n++) begin
            bp_put(n);
            bp_valid = 1;
            chk("bp_fill_ordy", 32'(bp_ordy), 32'h1);
            tick;
        end
        bp_put(3);
        chk("bp_full_ordy", 32'(bp_ordy), 32'h0);
        chk("bp_full_ovalid", 32'(bp_ovalid), 32'h1);
        chk("bp_full_res", 32'(bp_res), 32'h11);
        tick;
        chk("bp_stall_ordy", 32'(bp_ordy), 32'h0);
        chk("bp_stall_hold", 32'(bp_res), 32'h11);
        bp_iready = 1;
        #1;
        chk("bp_release_ordy", 32'(bp_ordy), 32'h1);
        tick;
        chk("bp_drain_w1", 32'(bp_res), 32'h22);
        bp_put(4);
        tick;
        bp_valid = 0;
        chk("bp_drain_w2", 32'(bp_res), 32'h33);
        tick;
        chk("bp_drain_w3", 32'(bp_res), 32'h44);
        tick;
        chk("bp_drain_w4", 32'(bp_res), 32'h55);
        chk("bp_drain_w4_valid", 32'(bp_ovalid), 32'h1);
        tick;
        chk("bp_empty", 32'(bp_ovalid), 32'h0);

        // Clear with a full pipeline and a concurrent input transfer.
        bp_iready = 0;
        for (int n = 0; n < 3; n++) begin
            bp_put(n);
            bp_valid = 1;
            tick;
        end
        chk("clr_full_ordy", 32'(bp_ordy), 32'h0);
        bp_iready = 1;
        bp_clear  = 1;
        bp_put(8);
        #1;
        chk("clr_ordy_unaffected", 32'(bp_ordy), 32'h1);
        tick;
        bp_clear = 0;
        bp_valid = 0;
        chk("clr_flush", 32'(bp_ovalid), 32'h0);
        for (int n = 0; n < 3; n++) begin
            tick;
            chk("clr_dropped", 32'(bp_ovalid), 32'h0);
        end

        // Asynchronous reset in the middle of a stalled stream.
        bp_iready = 0;
        for (int n = 0; n < 3; n++) begin
            bp_put(n);
            bp_valid = 1;
            tick;
        end
        bp_valid = 0;
        chk("mid_pre_ovalid", 32'(bp_ovalid), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_ovalid", 32'(bp_ovalid), 32'h0);
        chk("mid_rst_ordy", 32'(bp_ordy), 32'h1);
`ifdef RGGEN_PIPELINED_REDUCER_DATA_RESET_EN
        chk("mid_rst_res", 32'(bp_res), 32'h0);
`endif
        #1 rst_n = 1'b1;
        one_data  = 16'hCAFE;
        one_valid = 1;
        tick;
        one_valid = 0;
        chk("post_rst_valid", 32'(one_ovalid), 32'h1);
        chk("post_rst_res", 32'(one_res), 32'hCAFE);
        tick;
        chk("post_rst_drained", 32'(one_ovalid), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rggen_pipelined_reducer.md
# rggen_pipelined_reducer

Parametrised, pipelined N-to-1 bitwise reducer with a valid/ready handshake on both sides. It folds N input words of WIDTH bits into one word using a selectable operation (OR, AND or XOR). Pipeline registers are placed at a configurable interval inside the radix-4 reduction tree. It serves wide register-map read-data and interrupt-status muxes where a purely combinational reduction would not close timing.

## Interface
- WIDTH, 1, bit width of each input word and of the result
- N, 2, number of input words (≥1)
- OP, 0, reduction operation: 0 = OR, 1 = AND, 2 = XOR; any other value elaborates as OR
- REG_INTERVAL, 1, number of tree levels between pipeline registers (≥1)

- i_clk  input  1  clock; all state updates on the rising edge
- i_rst_n  input  1  reset, asynchronous assert, active-low
- i_clear  input  1  synchronous flush of all in-flight words
- i_valid  input  1  input word set valid
- o_ready  output  1  block accepts i_data this cycle
- i_data  input  WIDTH*N  input words; word k is i_data[WIDTH*k+:WIDTH]
- o_valid  output  1  o_result valid
- i_ready  input  1  downstream accepts o_result
- o_result  output  WIDTH  reduced word

## Operation
- Level structure: n0 = N; n(j+1) = ceil(n(j)/4); levels continue until the count is 1. L = number of levels; L = 0 when N = 1.
- Within a level, words are grouped in order, in groups of 4 with the remainder in the last group. Each group output is the OP-reduction of its members. A single-member group passes its word through.
- Register stages:
  - A register follows level REG_INTERVAL, level 2*REG_INTERVAL, and so on.
  - A register always follows the final level.
  - Depth D = ceil(L/REG_INTERVAL); D = 1 when L = 0, a pure register stage.
  - Examples: N=16, RI=1 gives L=2, D=2. N=64, RI=2 gives L=3, D=2.
- Each stage k (0..D-1) holds a valid bit v[k] and data.
- Stage-ready chain:
  - rdy[D-1] = !v[D-1] | i_ready.
  - rdy[k] = !v[k] | rdy[k+1].
  - o_ready = rdy[0].
  - The chain is combinational, with no bubble penalty.
- Stage k loads when rdy[k] is high:
  - v[k] takes the upstream valid (i_valid for k = 0).
  - Data takes the upstream combinational level result.
- Outputs: o_valid = v[D-1]; o_result = data of stage D-1.
- Transfer rules:
  - An input transfer occurs when i_valid & o_ready.
  - An output transfer occurs when o_valid & i_ready.
  - o_result is held stable while o_valid & !i_ready.
- i_clear:
  - Clears all v[k] at the next edge and drops the data in flight.
  - It has priority over a simultaneous input transfer; that input word is discarded.
  - o_ready is unaffected.
- Arithmetic: purely bitwise, width WIDTH at every level. There is no carry and no width growth.

## Timing
- Reset values (async on i_rst_n low): all v[k] = 0, so o_valid = 0. o_ready = 1. o_result per Configuration.
- Latency: D cycles from an input transfer to o_valid, provided no stall.
- Throughput: one word per cycle while i_ready is high.
- Full pipeline with i_ready low:
  - o_ready goes low combinationally once all D stages are valid.
  - Exactly D words are buffered; none are lost or duplicated.
- Bubbles: an empty stage accepts regardless of downstream state, so bubbles collapse.
- Reset asserted mid-operation drops all in-flight words immediately. Deassertion is synchronised externally; the first acceptance can occur on the first edge after release.

## Configuration
- RGGEN_PIPELINED_REDUCER_DATA_RESET_EN:
  - Defined: stage data registers reset asynchronously to 0, so o_result = 0 after reset.
  - Undefined: only the valid bits are reset. Data registers have no reset and o_result is undefined until the first transfer reaches the last stage.
  - Handshake behaviour is identical in both cases.

## Test plan
- OR reduction, WIDTH=8, N=16, RI=1 (D=2): send words 0x01,0x02,…,0x80 in slots 0–7, zeros in slots 8–15, i_ready=1 -> o_valid two cycles later, o_result=0xFF.
- AND/XOR check, WIDTH=4, N=5:
  - OP=1, all slots 0xF except slot 4=0x7 -> 0x7.
  - OP=2, slots 0x1,0x3,0x0,0x0,0x2 -> 0x0.
- Backpressure, N=64, RI=1 (D=3): stream 5 words with i_ready=0 -> o_ready drops after 3 accepted. Raising i_ready drains the words in order with no loss or duplication.
- N=1, WIDTH=16: input 0xBEEF -> o_result=0xBEEF, o_valid exactly 1 cycle after acceptance.
- i_clear with the pipeline full and i_valid=1 in the same cycle -> next cycle all v=0 and o_valid=0. The concurrent input is dropped.
- Reset mid-stream: assert i_rst_n=0 asynchronously -> o_valid=0 immediately. With the macro defined, o_result=0.
